// File: rtl/multi_channel_timer.sv
// Multi-channel timer: a shared free-running prescaler feeds CHANNELS independent
// period counters, each emitting a one-cycle elapsed pulse per completed period.

// One timer channel: IDLE/RUNNING state, up-counter, latched period and mode.
module mct_channel #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_s2_n,
  input  logic             i_tick,
  input  logic             i_en,
  input  logic             i_start,
  input  logic             i_one_shot,
  input  logic [WIDTH-1:0] i_period,
  output logic             o_elapsed,
  output logic             o_running
);
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_count, r_period_q, w_last;
  logic             r_mode_q, r_elapsed;
  logic             w_adv, w_term;

  // RUN implies period_q != 0, so period_q-1 never underflows while it matters.
  assign w_last = r_period_q - WIDTH'(1);
  assign w_adv  = (r_state == RUN) && i_en && i_tick;
  assign w_term = w_adv && (r_count == w_last);

  // State register
  always_ff @(posedge clock or negedge reset_s2_n) begin
    if (!reset_s2_n) r_state <= IDLE;
    else             r_state <= w_state_nxt;
  end

  // Next state: start dominates; a one-shot terminal count drops back to IDLE
  always_comb begin
    w_state_nxt = r_state;
    if (i_start)
      w_state_nxt = (i_period != '0) ? RUN : IDLE;
    else if (w_term && r_mode_q)
      w_state_nxt = IDLE;
  end

  // Datapath: latch on start, wrap and pulse on terminal, otherwise count
  always_ff @(posedge clock or negedge reset_s2_n) begin
    if (!reset_s2_n) begin
      r_count    <= '0;
      r_period_q <= '0;
      r_mode_q   <= 1'b0;
      r_elapsed  <= 1'b0;
    end else begin
      r_elapsed <= 1'b0;
      if (i_start) begin
        r_period_q <= i_period;
        r_mode_q   <= i_one_shot;
        r_count    <= '0;
      end else if (w_term) begin
        r_count   <= '0;
        r_elapsed <= 1'b1;
      end else if (w_adv) begin
        r_count <= r_count + WIDTH'(1);
      end
    end
  end

  // Outputs come straight from registers
  always_comb begin
    o_elapsed = r_elapsed;
    o_running = (r_state == RUN);
  end
endmodule

module multi_channel_timer #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 32,
  parameter int PRESCALE = 1
) (
  input  logic                      clock,
  input  logic                      reset_s2_n,
  input  logic [CHANNELS-1:0]       enabled,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS-1:0]       one_shot,
  input  logic [CHANNELS*WIDTH-1:0] period,
  output logic [CHANNELS-1:0]       elapsed,
  output logic [CHANNELS-1:0]       running
);
  logic                             w_tick;
  logic [CHANNELS-1:0][WIDTH-1:0]   w_period;

  assign w_period = period;

  if (PRESCALE <= 1) begin : g_nops
    assign w_tick = 1'b1;
  end else begin : g_ps
    localparam int PSW = $clog2(PRESCALE);
    localparam logic [PSW-1:0] PS_LAST = PSW'(PRESCALE - 1);
    logic [PSW-1:0] r_ps;

    // Free-running prescaler, never disturbed by channel starts
    always_ff @(posedge clock or negedge reset_s2_n) begin
      if (!reset_s2_n)         r_ps <= '0;
      else if (r_ps == PS_LAST) r_ps <= '0;
      else                     r_ps <= r_ps + PSW'(1);
    end

    assign w_tick = (r_ps == PS_LAST);
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    mct_channel #(.WIDTH(WIDTH)) u_ch (
      .clock      (clock),
      .reset_s2_n (reset_s2_n),
      .i_tick     (w_tick),
      .i_en       (enabled[g]),
      .i_start    (start[g]),
      .i_one_shot (one_shot[g]),
      .i_period   (w_period[g]),
      .o_elapsed  (elapsed[g]),
      .o_running  (running[g])
    );
  end
endmodule
